// File: rtl/latch_check_pkg.sv
// Shared types and constants for the latch checker: FSM state encoding and count width.
package latch_check_pkg;

  localparam int CNT_W = 8;
  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ARM  = 2'd1,
    RUN  = 2'd2,
    DONE = 2'd3
  } state_t;

endpackage

// File: rtl/latch_checker_stable_detect.sv
// Stability tracker for the d/en stimulus: counts cycles with unchanged inputs and
// strobes once, in the cycle the count first reaches SETTLE.
module stable_detect #(
  parameter int SETTLE = 2
) (
  input  logic clk,
  input  logic rst,
  input  logic clr,
  input  logic d,
  input  logic en,
  output logic cmp_strobe
);

  localparam int CW = 4;
  localparam logic [CW-1:0] SETTLE_C = CW'(SETTLE);

  logic [CW-1:0] cnt_q;
  logic [CW-1:0] cnt_d;
  logic          d_q;
  logic          en_q;
  logic          changed;

  // A change in the same cycle the count would reach SETTLE restarts without a strobe.
  always_comb begin
    changed    = (d != d_q) || (en != en_q);
    cnt_d      = cnt_q;
    cmp_strobe = 1'b0;
    if (clr || changed) begin
      cnt_d = '0;
    end else if (cnt_q != SETTLE_C) begin
      cnt_d      = cnt_q + 1'b1;
      cmp_strobe = (cnt_d == SETTLE_C);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q <= '0;
      d_q   <= 1'b0;
      en_q  <= 1'b0;
    end else begin
      cnt_q <= cnt_d;
      d_q   <= d;
      en_q  <= en;
    end
  end

endmodule

// File: rtl/latch_checker.sv
// Self-test checker for a D latch: tracks the expected latch value and compares q once per
// stable input interval. Define LATCH_CHECKER_QBAR_EN to also require qbar == ~q.
module latch_checker
  import latch_check_pkg::*;
#(
  parameter int SETTLE  = 2,
  parameter int NUM_CMP = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             d,
  input  logic             en,
  input  logic             q,
  input  logic             qbar,
  output logic             busy,
  output logic             done,
  output logic             pass,
  output logic [CNT_W-1:0] err_count,
  output logic [CNT_W-1:0] cmp_count
);

  localparam logic [CNT_W-1:0] NUM_CMP_C = CNT_W'(NUM_CMP);

  state_t           state_q;
  logic             exp_q;
  logic [CNT_W-1:0] err_q;
  logic [CNT_W-1:0] cmp_q;
  logic             busy_q;
  logic             done_q;
  logic             pass_q;

  logic arm_entry;
  logic cmp_strobe;
  logic mism;
  logic do_cmp;

  assign arm_entry = start && ((state_q == IDLE) || (state_q == DONE));
  assign do_cmp    = (state_q == RUN) && cmp_strobe && (cmp_q != NUM_CMP_C);

`ifdef LATCH_CHECKER_QBAR_EN
  // A broken complement counts as at most one error alongside a q mismatch.
  assign mism = (q != exp_q) || (qbar == q);
`else
  logic qbar_unused;
  assign qbar_unused = qbar;
  assign mism        = (q != exp_q);
`endif

  stable_detect #(
    .SETTLE(SETTLE)
  ) u_stable (
    .clk       (clk),
    .rst       (rst),
    .clr       (arm_entry),
    .d         (d),
    .en        (en),
    .cmp_strobe(cmp_strobe)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      exp_q   <= 1'b0;
      err_q   <= '0;
      cmp_q   <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      pass_q  <= 1'b0;
    end else begin
      case (state_q)
        IDLE, DONE: begin
          if (start) begin
            state_q <= ARM;
            busy_q  <= 1'b1;
            done_q  <= 1'b0;
            pass_q  <= 1'b0;
            err_q   <= '0;
            cmp_q   <= '0;
          end
        end
        // The latch content is unknown until it has been transparent once.
        ARM: begin
          if (en) begin
            exp_q   <= d;
            state_q <= RUN;
          end
        end
        RUN: begin
          if (en) exp_q <= d;
          if (cmp_q == NUM_CMP_C) begin
            state_q <= DONE;
            busy_q  <= 1'b0;
            done_q  <= 1'b1;
            pass_q  <= (err_q == '0);
          end else if (do_cmp) begin
            cmp_q <= cmp_q + 1'b1;
            if (mism && (err_q != CNT_MAX)) err_q <= err_q + 1'b1;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign busy      = busy_q;
  assign done      = done_q;
  assign pass      = pass_q;
  assign err_count = err_q;
  assign cmp_count = cmp_q;

endmodule

// File: doc/latch_checker.md
LATCH_CHECKER -- requirements
Module: latch_checker

Interface
REQ-001 SHALL have parameter SETTLE, default 2: system-clock cycles that d/en must stay stable before q is compared (range 1..15).
REQ-002 SHALL have parameter NUM_CMP, default 8: number of comparisons per run (range 1..255).
REQ-003 SHALL have port clk, input, 1 bit: the only clock; all state updates on its rising edge.
REQ-004 SHALL have port rst, input, 1 bit: asynchronous, active-high reset.
REQ-005 SHALL have port start, input, 1 bit: single-cycle pulse that begins a run.
REQ-006 SHALL have port d, input, 1 bit: data currently applied to the latch under test.
REQ-007 SHALL have port en, input, 1 bit: enable currently applied to the latch under test (high = transparent).
REQ-008 SHALL have port q, input, 1 bit: latch output.
REQ-009 SHALL have port qbar, input, 1 bit: latch complement output.
REQ-010 SHALL have port busy, output, 1 bit: high in ARM and RUN.
REQ-011 SHALL have port done, output, 1 bit: high in DONE.
REQ-012 SHALL have port pass, output, 1 bit: high in DONE only when err_count == 0.
REQ-013 SHALL have port err_count, output, 8 bits: mismatches in the current or last run, saturating at 255.
REQ-014 SHALL have port cmp_count, output, 8 bits: comparisons performed in the current or last run.

Function
REQ-015 SHALL implement FSM states IDLE, ARM, RUN, DONE.
REQ-016 SHALL transition IDLE->ARM on start; on entry, clear err_count, cmp_count and the stability counter.
REQ-017 SHALL, in ARM, wait for en==1 sampled, then load exp=d and go to RUN; no compare occurs in ARM because the latch state is unknown.
REQ-018 SHALL, in RUN, track the expected value every cycle: exp<=d when en==1, else hold exp.
REQ-019 SHALL keep a stability counter: reset to 0 when d or en differs from its previous-cycle value, otherwise increment, saturating at SETTLE.
REQ-020 SHALL compare exactly once per stable interval, in the cycle the counter first reaches SETTLE: cmp_count+1; err_count+1 (saturating) if q!=exp.
REQ-021 SHALL go RUN->DONE in the cycle after cmp_count reaches NUM_CMP; counters freeze in DONE.
REQ-022 SHALL go DONE->ARM on start (a new run); start in ARM or RUN is ignored.
REQ-023 SHALL, in the same-cycle event where d changes while the counter would reach SETTLE, restart the counter with no compare.
REQ-024 SHALL, on en falling, hold exp at the d value sampled in the last en==1 cycle.
REQ-025 SHALL, on DONE, leave outputs stable until start or rst.

Reset
REQ-026 SHALL, on asserted rst, force IDLE immediately, clearing busy, done, pass, err_count, cmp_count, exp and the stability counter to 0.
REQ-027 SHALL abort any run on rst mid-ARM/RUN without setting done.
REQ-028 SHALL ignore start while rst is high.

Configuration
REQ-029 SHALL check qbar when macro LATCH_CHECKER_QBAR_EN is defined: each compare also counts one error (max one per compare) if qbar!=~q.
REQ-030 SHALL, without LATCH_CHECKER_QBAR_EN, leave the qbar port unused and compare q only.

Structure
REQ-031 SHALL place the state enum type (IDLE/ARM/RUN/DONE) and the 8-bit count width constant in shared package latch_check_pkg.
REQ-032 SHALL place the stability counter and compare strobe in sub-module stable_detect (inputs d, en; output cmp_strobe).

Verification
REQ-033 Reference behavioural latch, SETTLE=2, NUM_CMP=8, start, apply d/en sequence with 2-cycle holds -> done=1, pass=1, err_count=0, cmp_count=8.
REQ-034 q stuck at 0 with a d=1, en=1 step -> err_count>=1, pass=0 at done.
REQ-035 d toggling every cycle while en=1 -> no compare until d stable for 2 cycles; cmp_count does not advance.
REQ-036 en=0 from start -> stays ARM, busy=1, cmp_count=0; en=1, d=1 -> enters RUN with exp=1.
REQ-037 rst asserted mid-RUN after 3 compares -> IDLE at once, all outputs 0, done never asserted.
REQ-038 With LATCH_CHECKER_QBAR_EN, qbar tied equal to q -> err_count=8 after 8 compares; without the macro -> err_count=0.
